fetch_unit: RTL

Instruction-fetch and sequencing stage of the accumulator CPU, directly upstream of the control unit. Holds the program counter and instruction register, and fetches words over a req/ack memory handshake. It presents the opcode fields (insMode, insShort, insLong) and the operand address to the control unit for one execute phase. It then consumes the control unit's stop and pcWR results to choose the next PC or to halt.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 25 ++
 rtl/ins_splitter.sv | 20 ++
 rtl/fetch_unit.sv | 83 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: address width, opcode encodings
// and the fetch-stage state type.
package cpu_pkg;

    localparam int ADDR_W = 8;

    // Short opcodes occupy IR[top:top-2]; long opcodes use the whole nibble.
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_CLA = 3'b011;
    localparam logic [2:0] OP_COM = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_BAN = 4'b1100;
    localparam logic [3:0] OP_SHR = 4'b1101;
    localparam logic [3:0] OP_CSL = 4'b1110;
    localparam logic [3:0] OP_STP = 4'b1111;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ack/data back.
interface fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memAck;
    logic [ADDR_W+3:0] memRdata;

    modport master (
        output memReq,
        output memAddr,
        input  memAck,
        input  memRdata
    );

    modport slave (
        input  memReq,
        input  memAddr,
        output memAck,
        output memRdata
    );

endinterface

// File: rtl/ins_splitter.sv
// Purely combinational split of an instruction word into its opcode views
// and operand address; shared with the disassembler monitor.
module ins_splitter #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W+3:0] ir,
    output logic              insMode,
    output logic [2:0]        insShort,
    output logic [3:0]        insLong,
    output logic [ADDR_W-1:0] opAddr
);

    assign insLong  = ir[ADDR_W+3:ADDR_W];
    assign insShort = ir[ADDR_W+3:ADDR_W+1];
    assign opAddr   = ir[ADDR_W-1:0];

    // Nibbles 1010/1011 are the short jmp, so a set top bit alone is not enough.
    assign insMode  = ir[ADDR_W+3] & (ir[ADDR_W+2:ADDR_W+1] != 2'b01);

endmodule

// File: rtl/fetch_unit.sv
// Fetch/sequencing stage: owns PC and IR, fetches over the req/ack port and
// hands one decoded instruction at a time to the control unit.
module fetch_unit #(
    parameter int              ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstN,
    fetch_unit_if.master      mem,
    output logic              insMode,
    output logic [2:0]        insShort,
    output logic [3:0]        insLong,
    output logic [ADDR_W-1:0] opAddr,
    output logic              execValid,
    input  logic              exeReady,
    input  logic              pcWR,
    input  logic              stop,
    output logic              halted
);

    import cpu_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W+3:0] ir;
    logic              fetch_done;
    logic              exec_done;

    assign fetch_done = (state == FETCH) && mem.memAck;
    assign exec_done  = (state == EXEC) && exeReady;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:  state_next = FETCH;
            FETCH: if (fetch_done) state_next = EXEC;
            EXEC:  if (exec_done)  state_next = stop ? HALT : FETCH;
            HALT:  state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    // NOTE: reset here is synchronous, so rstN appears only inside the
    // clocked branch and never in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstN) state <= BOOT;
        else       state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            pc <= RESET_PC;
            ir <= '0;
        end else if (fetch_done) begin
            ir <= mem.memRdata;
            pc <= pc + ADDR_W'(1);
        end else if (exec_done && !stop && pcWR) begin
            pc <= opAddr;
        end
    end

    // Outputs come only from registers, so no input reaches an output combinationally.
    assign mem.memReq  = (state == FETCH);
    assign mem.memAddr = pc;
    assign execValid   = (state == EXEC);
    assign halted      = (state == HALT);

    ins_splitter #(
        .ADDR_W (ADDR_W)
    ) u_ins_splitter (
        .ir       (ir),
        .insMode  (insMode),
        .insShort (insShort),
        .insLong  (insLong),
        .opAddr   (opAddr)
    );

endmodule
